// File: rtl/key_scheduler_reverse_sequential.sv
// Reverse AES-256 key scheduler: streams RK14..RK0 from {RK13, RK14}, then the cipher key.
// Optional macro KEY_SCHED_REV_INV_MIXCOL_EN emits RK13..RK1 as equivalent inverse cipher keys.
module key_scheduler_reverse_sequential #(
  parameter int unsigned NB_BYTE       = 8,
  parameter int unsigned N_BYTES_STATE = 16,
  parameter int unsigned N_BYTES_KEY   = 32,
  parameter int unsigned N_ROUNDS      = 14
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_valid,
  input  logic                              i_trigger,
  input  logic [NB_BYTE*N_BYTES_KEY-1:0]    i_last_key,
  output logic [NB_BYTE*N_BYTES_STATE-1:0]  o_round_key,
  output logic [3:0]                        o_round_index,
  output logic                              o_round_key_valid,
  output logic [NB_BYTE*N_BYTES_KEY-1:0]    o_cipher_key,
  output logic                              o_key_ready,
  output logic                              o_done,
  output logic                              o_busy
);

  localparam int unsigned WORD_W = 4 * NB_BYTE;
  localparam int unsigned KEY_W  = NB_BYTE * N_BYTES_KEY;
  localparam int unsigned RK_W   = NB_BYTE * N_BYTES_STATE;

  if (NB_BYTE != 8) begin : g_bad_conf
    $error("BAD_CONF: NB_BYTE must be 8");
  end

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT14,
    ST_EMIT13,
    ST_EXPAND,
    ST_FINISH
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [2:0] sel);
    case (sel)
      3'd0:    return 8'h01;
      3'd1:    return 8'h02;
      3'd2:    return 8'h04;
      3'd3:    return 8'h08;
      3'd4:    return 8'h10;
      3'd5:    return 8'h20;
      3'd6:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

`ifdef KEY_SCHED_REV_INV_MIXCOL_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [RK_W-1:0] key_xform(input logic [RK_W-1:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction
`else
  function automatic logic [RK_W-1:0] key_xform(input logic [RK_W-1:0] k);
    return k;
  endfunction
`endif

  state_t              state, state_d;
  logic [KEY_W-1:0]    window, window_d;
  logic [3:0]          cnt, cnt_d;
  logic [RK_W-1:0]     round_key_d;
  logic [3:0]          round_index_d;
  logic                round_key_valid_d;
  logic [KEY_W-1:0]    cipher_key_d;
  logic                key_ready_d, done_d, busy_d;

  // Window words w[j+3..j+7] feed the four backward recurrences.
  logic [WORD_W-1:0] w3, w4, w5, w6, w7;
  assign w3 = window[5*WORD_W-1 -: WORD_W];
  assign w4 = window[4*WORD_W-1 -: WORD_W];
  assign w5 = window[3*WORD_W-1 -: WORD_W];
  assign w6 = window[2*WORD_W-1 -: WORD_W];
  assign w7 = window[WORD_W-1:0];

  // Only the lowest new word sees a T transform; cnt parity picks RotSub+Rcon (even) or Sub (odd).
  logic [WORD_W-1:0] sub_rot, sub_plain, t_word;
  logic [RK_W-1:0]   new_words;
  always_comb begin
    sub_rot   = sub_word({w3[23:0], w3[31:24]});
    sub_plain = sub_word(w3);
    t_word    = cnt[0] ? sub_plain : (sub_rot ^ {rcon_lut(cnt[3:1]), 24'h000000});
    new_words = {w4 ^ t_word, w5 ^ w4, w6 ^ w5, w7 ^ w6};
  end

  always_comb begin
    state_d           = state;
    window_d          = window;
    cnt_d             = cnt;
    round_key_d       = o_round_key;
    round_index_d     = o_round_index;
    round_key_valid_d = 1'b0;
    cipher_key_d      = o_cipher_key;
    key_ready_d       = o_key_ready;
    done_d            = 1'b0;
    busy_d            = o_busy;
    if (i_valid) begin
      if (i_trigger) begin
        state_d     = ST_EMIT14;
        window_d    = i_last_key;
        busy_d      = 1'b1;
        key_ready_d = 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_EMIT14: begin
            round_key_d       = window[RK_W-1:0];
            round_index_d     = 4'(N_ROUNDS);
            round_key_valid_d = 1'b1;
            state_d           = ST_EMIT13;
          end
          ST_EMIT13: begin
            round_key_d       = key_xform(window[KEY_W-1:RK_W]);
            round_index_d     = 4'(N_ROUNDS - 1);
            round_key_valid_d = 1'b1;
            cnt_d             = 4'(N_ROUNDS - 2);
            state_d           = ST_EXPAND;
          end
          ST_EXPAND: begin
            round_key_d       = (cnt == 4'd0) ? new_words : key_xform(new_words);
            round_index_d     = cnt;
            round_key_valid_d = 1'b1;
            window_d          = {new_words, window[KEY_W-1:RK_W]};
            if (cnt == 4'd0) state_d = ST_FINISH;
            else             cnt_d   = cnt - 4'd1;
          end
          ST_FINISH: begin
            cipher_key_d = window;
            done_d       = 1'b1;
            key_ready_d  = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      window            <= '0;
      cnt               <= '0;
      o_round_key       <= '0;
      o_round_index     <= '0;
      o_round_key_valid <= 1'b0;
      o_cipher_key      <= '0;
      o_key_ready       <= 1'b0;
      o_done            <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      state             <= state_d;
      window            <= window_d;
      cnt               <= cnt_d;
      o_round_key       <= round_key_d;
      o_round_index     <= round_index_d;
      o_round_key_valid <= round_key_valid_d;
      o_cipher_key      <= cipher_key_d;
      o_key_ready       <= key_ready_d;
      o_done            <= done_d;
      o_busy            <= busy_d;
    end
  end

endmodule

// File: doc/key_scheduler_reverse_sequential.md
Name: key_scheduler_reverse_sequential

Overview:
- Reverse AES-256 key scheduler. Takes the final two round keys (rounds 13 and 14) and runs the key expansion backwards, four words per cycle.
- Streams round keys in decryption order, RK14 down to RK0, then presents the recovered 256-bit cipher key.
- Sits in front of the decryption round pipeline. It is the counterpart of the forward sequential key scheduler: the decrypt path needs keys in inverse order and must not store the full 1920-bit vector.

Parameters:
- NB_BYTE, 8, bits per byte; any other value flags BAD_CONF.
- N_BYTES_STATE, 16, bytes per round key.
- N_BYTES_KEY, 32, cipher key bytes (NK = 8 words).
- N_ROUNDS, 14, number of rounds; round index width is 4 bits.

Ports:
- i_clock, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_valid, in, 1, clock enable; no state changes when low.
- i_trigger, in, 1, starts a new reverse schedule when high together with i_valid.
- i_last_key, in, 256, {RK13, RK14}: [255:128] = w[52..55], [127:0] = w[56..59]; word w[i] MSB-first, byte 0 in MSBs (FIPS-197 order).
- o_round_key, out, 128, current round key, {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- o_round_index, out, 4, round number r of o_round_key.
- o_round_key_valid, out, 1, one-cycle strobe per produced key.
- o_cipher_key, out, 256, recovered {w0..w7}; valid while o_key_ready is high.
- o_key_ready, out, 1, level; set with o_done, cleared on trigger or reset.
- o_done, out, 1, one-cycle pulse after RK0 is emitted.
- o_busy, out, 1, high from trigger until o_done.

Behaviour:
- Reset: state IDLE; window, o_round_key, o_cipher_key = 0; o_round_index = 0; all strobes, o_busy and o_key_ready = 0.
- Window register: 8 words, W = w[j..j+7], with j = 52 at trigger.
- Backward recurrence, all 4 new words computed in parallel from the window:
  - w[i-8] = w[i] ^ T_i(w[i-1]), for i = j+7 down to j+4, producing w[j-4..j-1].
  - T_i = SubWord(RotWord(x)) ^ Rcon[i/8] when i%8 == 0.
  - T_i = SubWord(x) when i%8 == 4.
  - T_i = x otherwise.
  - Rcon is selected from i/8 in the range 1..7, via a 7-entry LUT indexed by the round counter.
- There are 8 combinational S-boxes: 4 for the i%8 == 0 word, 4 for the i%8 == 4 word. No intra-cycle chaining.
- FSM, advancing only on i_valid cycles:
  - IDLE: on trigger, load window from i_last_key, go to EMIT14, o_busy = 1.
  - EMIT14: output RK14, index 14, valid strobe; go to EMIT13.
  - EMIT13: output RK13, index 13, valid strobe; set cnt = 12; go to EXPAND.
  - EXPAND: compute 4 new words; output them as RK[cnt]; window <= {new4, window upper 4 words}; decrement cnt. After cnt = 0 is emitted, go to FINISH.
  - FINISH: o_cipher_key <= window (w0..w7); o_done pulse; o_key_ready = 1; o_busy = 0; return to IDLE.
- Latency, with i_valid held high:
  - trigger at cycle T: RK14 registered at T+1, RK0 at T+15, o_done and o_cipher_key at T+16.
  - 15 key strobes total.
- i_valid low: all registers hold; o_round_key_valid and o_done are forced low that cycle. o_round_key keeps its last value.
- Trigger in any non-IDLE state: restart immediately from the new i_last_key, with no o_done for the aborted run. Trigger has priority over advance.
- Trigger in FINISH: o_done is suppressed and the restart wins.
- Reset mid-schedule: returns to the reset values on the next edge.
- Round index never wraps: cnt stops at 0 and the FSM leaves EXPAND.

Optional Feature:
- Macro KEY_SCHED_REV_INV_MIXCOL_EN.
- Defined: RK13..RK1 are passed through InvMixColumns on each 32-bit column before registering on o_round_key (equivalent inverse cipher keys). RK14 and RK0 are unmodified. The window always holds raw words. Latency is unchanged.
- Undefined: o_round_key carries the raw expanded words and the InvMixColumns logic is absent.

Test Plan:
- FIPS-197 C.3 key 000102…1f: drive i_last_key = forward-expanded {RK13, RK14} with i_valid = 1 -> RK14 = 24fc79ccbf0979e9371ac23c6d68de36 at T+1. Indices 14..0 must match the golden forward expansion. o_cipher_key = 000102…1f at T+16, with a single o_done.
- FIPS-197 A.3 key 603deb10…0914dff4: full run -> recovered key matches. Rcon positions at i = 56, 48…8 are exercised.
- i_valid toggled with a pseudo-random 50% pattern -> the same 15 keys arrive in the same order, no duplicate strobes, and o_done only after RK0.
- Re-trigger during EXPAND at cnt = 6 with a new key -> the next strobe is RK14 of the new key, no o_done from the aborted run, and o_key_ready stays 0.
- Reset asserted at cnt = 3 -> all outputs are zero next cycle; a later trigger runs a clean full schedule.
- With KEY_SCHED_REV_INV_MIXCOL_EN defined, C.3 key -> RK13..RK1 equal InvMixColumns(golden) and RK14/RK0 equal the raw keys.
